// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end: owns the PC, fetches words over a req/ack
// handshake and holds each instruction for decode behind a valid/ready handshake.
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PC_MUX_sel,
   input  logic [WIDTH-1:0] branch_target,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] instr,
   output logic [6:0]       opcode,
   output logic [WIDTH-1:0] instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

   state_t           state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] req_addr;
   logic             kill;
   logic [WIDTH-1:0] tgt;

   // Misaligned targets are silently word-aligned; no trap is raised.
   assign tgt       = branch_target & ALIGN_MASK;
   assign imem_addr = req_addr;
   assign opcode    = instr[6:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         kill        <= 1'b0;
         imem_req    <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
               if (PC_MUX_sel) begin
                  pc       <= tgt;
                  req_addr <= tgt;
               end else begin
                  req_addr <= pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  if (kill || PC_MUX_sel) begin
                     // Stale word: drop it and re-request straight at the target.
                     pc       <= PC_MUX_sel ? tgt : pc;
                     req_addr <= PC_MUX_sel ? tgt : pc;
                     kill     <= 1'b0;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= req_addr;
                     pc          <= req_addr + WIDTH'(4);
                     instr_valid <= 1'b1;
                     imem_req    <= 1'b0;
                     state       <= HOLD;
                  end
               end else if (PC_MUX_sel) begin
                  // Address bus must stay put until the outstanding ack arrives.
                  pc   <= tgt;
                  kill <= 1'b1;
               end
            end
            HOLD: begin
               if (PC_MUX_sel) begin
                  pc          <= tgt;
                  req_addr    <= tgt;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= REQ;
               end else if (instr_ready) begin
                  req_addr    <= pc;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= REQ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; the bench plays instruction memory
// and decode, driving inputs 1 time unit after each rising edge.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        PC_MUX_sel;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;

   int n_vec = 0;
   int n_bad = 0;

   fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .PC_MUX_sel   (PC_MUX_sel),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr        (instr),
      .opcode       (opcode),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] words [3] = '{32'h0000_0013, 32'h0010_0113, 32'h0020_0193};

   initial begin
      rst = 1'b0; PC_MUX_sel = 1'b0; branch_target = '0;
      imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      #1;
      chk("rst_req",    imem_req,    0);
      chk("rst_valid",  instr_valid, 0);
      chk("rst_instr",  instr,       0);
      chk("rst_ipc",    instr_pc,    0);
      chk("rst_addr",   imem_addr,   0);
      chk("rst_opcode", opcode,      0);
      step(); step();
      // Release with a spurious ack present: IDLE must ignore it.
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      rst = 1'b1;
      step();
      imem_ack = 1'b0;
      chk("idle_ack_ignored", instr_valid, 0);
      chk("first_req",        imem_req,    1);
      chk("first_addr",       imem_addr,   0);

      // Zero-wait memory, decode always ready.
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("zw_addr%0d", k), imem_addr, 32'(4*k));
         chk($sformatf("zw_req%0d", k),  imem_req,  1);
         imem_ack = 1'b1; imem_rdata = words[k];
         step();
         imem_ack = 1'b0;
         chk($sformatf("zw_valid%0d", k), instr_valid, 1);
         chk($sformatf("zw_ipc%0d", k),   instr_pc,    32'(4*k));
         chk($sformatf("zw_instr%0d", k), instr,       words[k]);
         chk($sformatf("zw_reqlo%0d", k), imem_req,    0);
         step();
         chk($sformatf("zw_vlo%0d", k),   instr_valid, 0);
      end
      instr_ready = 1'b0;
      chk("zw_next_addr", imem_addr, 32'hC);

      // Reset while a request is outstanding.
      rst = 1'b0;
      #1;
      chk("arst_req",   imem_req,    0);
      chk("arst_valid", instr_valid, 0);
      step();
      rst = 1'b1;
      step();

      // Three wait cycles before ack.
      chk("ws_addr0", imem_addr, 0);
      for (int i = 1; i < 4; i++) begin
         step();
         chk($sformatf("ws_addr%0d", i), imem_addr, 0);
         chk($sformatf("ws_req%0d", i),  imem_req,  1);
      end
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      step();
      imem_ack = 1'b0;
      chk("ws_valid",  instr_valid, 1);
      chk("ws_instr",  instr,       32'h0050_0093);
      chk("ws_opcode", opcode,      7'h13);

      // Stall in HOLD for five cycles.
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall_valid%0d", i), instr_valid, 1);
         chk($sformatf("stall_instr%0d", i), instr,       32'h0050_0093);
         chk($sformatf("stall_ipc%0d", i),   instr_pc,    0);
         chk($sformatf("stall_req%0d", i),   imem_req,    0);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("stall_done_valid", instr_valid, 0);
      chk("stall_next_addr",  imem_addr,   32'h4);

      // Fetch 0x4, consume it, then redirect while 0x8 is pending.
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      step();
      imem_ack = 1'b0; instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("kill_pend_addr", imem_addr, 32'h8);
      PC_MUX_sel = 1'b1; branch_target = 32'h0000_0102;
      step();
      PC_MUX_sel = 1'b0;
      chk("kill_hold_addr0", imem_addr, 32'h8);
      step();
      chk("kill_hold_addr1", imem_addr, 32'h8);
      chk("kill_hold_req",   imem_req,  1);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("kill_no_valid", instr_valid, 0);
      chk("kill_tgt_addr", imem_addr,   32'h100);
      chk("kill_tgt_req",  imem_req,    1);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0067;
      step();
      imem_ack = 1'b0;
      chk("tgt_valid", instr_valid, 1);
      chk("tgt_ipc",   instr_pc,    32'h100);
      chk("tgt_instr", instr,       32'h0000_0067);

      // Redirect in HOLD coinciding with accept.
      PC_MUX_sel = 1'b1; branch_target = 32'h40; instr_ready = 1'b1;
      step();
      PC_MUX_sel = 1'b0; instr_ready = 1'b0;
      chk("hold_redir_valid", instr_valid, 0);
      chk("hold_redir_addr",  imem_addr,   32'h40);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
      step();
      imem_ack = 1'b0;
      chk("hold_redir_ipc", instr_pc, 32'h40);

      // Misaligned target near the top of memory, then wrap.
      PC_MUX_sel = 1'b1; branch_target = 32'hFFFF_FFFE;
      step();
      PC_MUX_sel = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      step();
      imem_ack = 1'b0;
      chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      chk("wrap_next_addr", imem_addr, 32'h0);
      chk("wrap_next_req",  imem_req,  1);

      // Reset while an instruction is held.
      imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
      step();
      imem_ack = 1'b0;
      chk("pre_rst_valid", instr_valid, 1);
      rst = 1'b0;
      #1;
      chk("hrst_valid", instr_valid, 0);
      chk("hrst_req",   imem_req,    0);
      chk("hrst_instr", instr,       0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32I core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds each returned instruction in a register. It presents that instruction, its PC and its opcode field to `ctrl_unit` and the rest of decode over a valid/ready handshake. It also consumes the control unit's `PC_MUX_sel` redirect together with the branch/jump target.

## Interface
- `WIDTH`, 32: data/address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `PC_MUX_sel`  in  1  redirect request; single-cycle pulse, sampled every cycle.
- `branch_target`  in  WIDTH  redirect address; valid when `PC_MUX_sel`=1.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  WIDTH  read address, word aligned.
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  WIDTH  returned instruction word.
- `instr`  out  WIDTH  held instruction.
- `opcode`  out  7  `instr[6:0]`, the `opcode` input of `ctrl_unit`.
- `instr_pc`  out  WIDTH  address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` valid.
- `instr_ready`  in  1  decode accepts the instruction this cycle.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `instr`, `instr_pc`, `instr_valid`.
  - `kill`: redirect pending while a request is outstanding.
  - `state`.
- States:
  - IDLE: entered on reset only.
  - REQ: request outstanding.
  - HOLD: instruction presented to decode.
- IDLE → REQ unconditionally on the first clock after reset release.
- REQ behaviour:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - Both stay stable until the cycle in which `imem_ack`=1.
- REQ with `imem_ack`=1 and no kill:
  - Latch `instr`←`imem_rdata` and `instr_pc`←`pc`.
  - Set `pc`←`pc`+4, wrapping modulo 2^WIDTH.
  - Set `instr_valid`←1 and go to HOLD.
- REQ with `imem_ack`=1 and a kill (`kill`=1, or `PC_MUX_sel`=1 in the same cycle):
  - Discard the word.
  - Set `pc`←target, clear `kill`, stay in REQ.
  - A new request to the target issues on the next cycle.
- REQ with `PC_MUX_sel`=1 and no ack:
  - Set `pc`←`{branch_target[WIDTH-1:2],2'b00}` and `kill`←1.
  - `imem_addr` keeps its old value until ack, so `imem_addr` is driven from a separate `req_addr` register captured on entry to REQ.
- HOLD behaviour: `imem_req`=0 and `instr_valid`=1.
- HOLD with `instr_ready`=1 and no redirect: the instruction is consumed; `instr_valid`←0 and the block goes to REQ.
- HOLD with `PC_MUX_sel`=1:
  - Set `pc`←target (low bits forced to 0) and `instr_valid`←0, then go to REQ.
  - If `instr_ready`=1 in the same cycle, the transfer still counts as accepted.
- The low two bits of the target are always forced to 0. No misalignment trap is raised.
- `opcode` is continuously `instr[6:0]`. It is 0 when `instr` is 0.

## Timing
- Reset, asynchronous, while `rst`=0:
  - `pc`=`RESET_PC`, `req_addr`=`RESET_PC`.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `imem_req`=0, `kill`=0, state IDLE.
- Reset asserted mid-request: the outstanding request is abandoned. `imem_req` drops asynchronously, and any `imem_ack` received while in IDLE is ignored.
- Cycle 0 is the first edge after `rst` rises: IDLE→REQ, and `imem_req`=1 from cycle 1.
- With a zero-wait memory (ack in the same cycle as req), `instr_valid` rises on the next edge after the ack.
- Peak throughput is 1 instruction per 2 cycles: REQ, HOLD, REQ, ...
- A redirect takes effect on the next edge. The first request to the target asserts at most 1 cycle after the redirect, or 1 cycle after the pending ack.
- `instr`, `instr_pc` and `opcode` are stable while `instr_valid`=1 and `instr_ready`=0.

## Test plan
- Reset → release, then memory acks every request in the same cycle:
  - Addresses issued: 0x0, 0x4, 0x8.
  - `instr_pc` follows the same sequence, and `instr_valid` pulses every 2nd cycle.
- Memory acks after 3 wait cycles:
  - `imem_addr` is held at 0x0 for 4 cycles.
  - `instr`=0x00500093 is latched with `opcode`=7'h13.
- In HOLD with `instr_ready`=0 for 5 cycles, then 1:
  - Outputs stay unchanged for those 5 cycles.
  - Next request goes to `instr_pc`+4.
- `PC_MUX_sel`=1 with target 0x0000_0102 during a pending request at 0x8:
  - The acked word is dropped and no `instr_valid` is raised.
  - The next request is to 0x100.
- `PC_MUX_sel`=1 with target 0x40 in HOLD, with `instr_ready`=1 in the same cycle:
  - `instr_valid` drops, and the next request is to 0x40.
- `pc` at 0xFFFF_FFFC, then ack:
  - The next fetch address wraps to 0x0.
- `rst` asserted with `imem_req`=1: `imem_req` and `instr_valid` go to 0 immediately.
